// File: rtl/matrix_mul_pkg.sv
// Shared types and helpers for the matrix-multiply engine.
// State encoding, header layout, saturation and address helpers.
package matrix_mul_pkg;

  typedef enum logic [3:0] {
    IDLE,
    H0,
    H1,
    H2,
    H3,
    CHK,
    RDC,
    RDC2,
    LDA,
    LDB,
    MAC,
    WR,
    DONE
  } state_e;

  localparam logic [15:0] HDR_M_OFF = 16'h0000;
  localparam logic [15:0] HDR_K_OFF = 16'h0004;
  localparam logic [15:0] HDR_N_OFF = 16'h0008;

  localparam logic signed [63:0] S32_MAX =
    64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] S32_MIN =
    64'shFFFF_FFFF_8000_0000;

  function automatic logic [31:0] sat32(
    input logic signed [63:0] v
  );
    logic [31:0] r;
    if (v > S32_MAX) begin
      r = 32'h7FFF_FFFF;
    end else if (v < S32_MIN) begin
      r = 32'h8000_0000;
    end else begin
      r = v[31:0];
    end
    return r;
  endfunction

  // Row-major word address; index math wraps at 16 bits.
  function automatic logic [15:0] elem_addr(
    input logic [15:0] base,
    input logic [15:0] row,
    input logic [15:0] stride,
    input logic [15:0] col
  );
    logic [15:0] idx;
    idx = row * stride + col;
    return base + {idx[13:0], 2'b00};
  endfunction

  function automatic logic dim_ok(
    input logic [15:0] d,
    input logic [15:0] dmax
  );
    return (d != 16'd0) && (d <= dmax);
  endfunction

endpackage

// File: rtl/matrix_mul_engine_if.sv
// Host control plus single-port SRAM bus of the engine.
// master = engine side, slave = host/memory side.
interface matrix_mul_engine_if;
  logic        RUN;
  logic        ACC_MODE;
  logic [31:0] RDATA;
  logic [15:0] ADDR;
  logic        WEN;
  logic [31:0] WDATA;
  logic        INT;
  logic        ERR;
  logic        BUSY;

  modport master (
    input  RUN,
    input  ACC_MODE,
    input  RDATA,
    output ADDR,
    output WEN,
    output WDATA,
    output INT,
    output ERR,
    output BUSY
  );

  modport slave (
    output RUN,
    output ACC_MODE,
    output RDATA,
    input  ADDR,
    input  WEN,
    input  WDATA,
    input  INT,
    input  ERR,
    input  BUSY
  );
endinterface

// File: rtl/mac_unit.sv
// Multiply-accumulate datapath: operand extension, wide accumulator,
// and saturating/truncating 32-bit result of acc + a*b.
module mac_unit
  import matrix_mul_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SIGNED = 1,
  parameter int ACC_W  = 38,
  parameter int SAT_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [31:0]       load_val_i,
  input  logic              mac_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [31:0]       res_o
);
  localparam int PW = 2 * DATA_W + 2;

  logic                     ext_a;
  logic                     ext_b;
  logic signed [DATA_W:0]   a_x;
  logic signed [DATA_W:0]   b_x;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  sum_d;
  logic signed [63:0]       sum64;

  // One extra bit keeps unsigned operands positive in a signed multiply.
  assign ext_a = (SIGNED != 0) && a_i[DATA_W-1];
  assign ext_b = (SIGNED != 0) && b_i[DATA_W-1];
  assign a_x   = {ext_a, a_i};
  assign b_x   = {ext_b, b_i};
  assign prod  = PW'(a_x) * PW'(b_x);
  assign sum_d = acc_q + ACC_W'(prod);
  assign sum64 = 64'(sum_d);

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (load_i) begin
      acc_q <= ACC_W'($signed(load_val_i));
    end else if (mac_i) begin
      acc_q <= sum_d;
    end
  end

  assign res_o = (SAT_EN != 0) ? sat32(sum64)
                               : sum_d[31:0];

endmodule

// File: rtl/matrix_mul_engine.sv
// Memory-mapped C = A x B (or C += A x B) engine with fixed timing.
// FSM and address generation; arithmetic lives in mac_unit.
module matrix_mul_engine
  import matrix_mul_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          SIGNED   = 1,
  parameter int          MAX_DIM  = 64,
  parameter int          SAT_EN   = 1,
  parameter logic [15:0] HDR_BASE = 16'h0000,
  parameter logic [15:0] A_BASE   = 16'h1000,
  parameter logic [15:0] B_BASE   = 16'h6000,
  parameter logic [15:0] C_BASE   = 16'hA000
) (
  input logic                 clk,
  input logic                 rst,
  matrix_mul_engine_if.master bus
);
  localparam int ACC_W = 2 * DATA_W + $clog2(MAX_DIM);
  localparam logic [15:0] DIM_MAX = 16'(MAX_DIM);

  state_e            state_q;
  logic              run_q;
  logic              acc_mode_q;
  logic              big_q;
  logic [15:0]       md_q;
  logic [15:0]       kd_q;
  logic [15:0]       nd_q;
  logic [15:0]       i_q;
  logic [15:0]       j_q;
  logic [15:0]       k_q;
  logic [DATA_W-1:0] a_q;
  logic [15:0]       addr_q;
  logic              wen_q;
  logic [31:0]       wdata_q;
  logic              int_q;
  logic              err_q;
  logic              busy_q;

  logic              k_last;
  logic              j_last;
  logic              i_last;
  logic [15:0]       i_d;
  logic [15:0]       j_d;
  logic              dims_ok;
  logic [31:0]       mac_res;

  always_comb begin
    k_last  = (k_q == kd_q - 16'd1);
    j_last  = (j_q == nd_q - 16'd1);
    i_last  = (i_q == md_q - 16'd1);
    j_d     = j_last ? 16'd0 : j_q + 16'd1;
    i_d     = j_last ? i_q + 16'd1 : i_q;
    dims_ok = !big_q
           && dim_ok(md_q, DIM_MAX)
           && dim_ok(kd_q, DIM_MAX)
           && dim_ok(nd_q, DIM_MAX);
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .SIGNED (SIGNED),
    .ACC_W  (ACC_W),
    .SAT_EN (SAT_EN)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q == CHK || state_q == WR),
    .load_i     (state_q == RDC2),
    .load_val_i (bus.RDATA),
    .mac_i      (state_q == MAC),
    .a_i        (a_q),
    .b_i        (bus.RDATA[DATA_W-1:0]),
    .res_o      (mac_res)
  );

  // Outputs are registered: each branch sets what the next state shows.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      acc_mode_q <= 1'b0;
      big_q      <= 1'b0;
      md_q       <= '0;
      kd_q       <= '0;
      nd_q       <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      a_q        <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      int_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      run_q   <= bus.RUN;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (bus.RUN && !run_q) begin
            acc_mode_q <= bus.ACC_MODE;
            addr_q     <= HDR_BASE + HDR_M_OFF;
            busy_q     <= 1'b1;
            state_q    <= H0;
          end
        end
        H0: begin
          addr_q  <= HDR_BASE + HDR_K_OFF;
          state_q <= H1;
        end
        H1: begin
          md_q    <= bus.RDATA[15:0];
          big_q   <= |bus.RDATA[31:16];
          addr_q  <= HDR_BASE + HDR_N_OFF;
          state_q <= H2;
        end
        H2: begin
          kd_q    <= bus.RDATA[15:0];
          big_q   <= big_q | (|bus.RDATA[31:16]);
          state_q <= H3;
        end
        H3: begin
          nd_q    <= bus.RDATA[15:0];
          big_q   <= big_q | (|bus.RDATA[31:16]);
          state_q <= CHK;
        end
        CHK: begin
          i_q <= '0;
          j_q <= '0;
          k_q <= '0;
          if (!dims_ok) begin
            int_q   <= 1'b1;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else if (acc_mode_q) begin
            addr_q  <= C_BASE;
            state_q <= RDC;
          end else begin
            addr_q  <= A_BASE;
            state_q <= LDA;
          end
        end
        RDC: state_q <= RDC2;
        RDC2: begin
          addr_q  <= elem_addr(A_BASE, i_q, kd_q, 16'd0);
          state_q <= LDA;
        end
        LDA: begin
          addr_q  <= elem_addr(B_BASE, k_q, nd_q, j_q);
          state_q <= LDB;
        end
        LDB: begin
          a_q     <= bus.RDATA[DATA_W-1:0];
          state_q <= MAC;
        end
        MAC: begin
          if (k_last) begin
            wen_q   <= 1'b1;
            wdata_q <= mac_res;
            addr_q  <= elem_addr(C_BASE, i_q, nd_q, j_q);
            state_q <= WR;
          end else begin
            k_q     <= k_q + 16'd1;
            addr_q  <= elem_addr(A_BASE, i_q, kd_q,
                                 k_q + 16'd1);
            state_q <= LDA;
          end
        end
        WR: begin
          k_q <= '0;
          i_q <= i_d;
          j_q <= j_d;
          if (i_last && j_last) begin
            int_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else if (acc_mode_q) begin
            addr_q  <= elem_addr(C_BASE, i_d, nd_q, j_d);
            state_q <= RDC;
          end else begin
            addr_q  <= elem_addr(A_BASE, i_d, kd_q, 16'd0);
            state_q <= LDA;
          end
        end
        DONE: begin
          if (!bus.RUN) begin
            int_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ADDR  = addr_q;
  assign bus.WEN   = wen_q;
  assign bus.WDATA = wdata_q;
  assign bus.INT   = int_q;
  assign bus.ERR   = err_q;
  assign bus.BUSY  = busy_q;

endmodule
